i2c_target_rx: RTL and testbench
================================

Name: i2c_target_rx

Overview:
Write-only I²C target (slave receiver) for the FM radio design: it is the bus-side responder to an I²C write controller. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit address, ACKs by pulling SDA low, and shifts in NBYTES data bytes MSB first. A complete transfer is presented as a parallel register word with a one-cycle valid strobe. It is used as a register-bank front end and as a loopback checker for the controller.

Parameters:
ADDR, 7'h10, 7-bit target address to match.
NBYTES, 2, data bytes per transaction; must be at least 1.
SYNC_STAGES, 2, synchronizer flops per bus input; must be at least 2.

Ports:
clk  input  1  system clock; must be at least 16x the SCL rate.
reset  input  1  asynchronous, active-high reset.
SCL  input  1  I²C clock, asynchronous to clk.
SDA  input  1  I²C data, asynchronous to clk.
sda_oe  output  1  1 = pull SDA low (open-drain ACK); 0 = release.
wdata  output  [NBYTES-1:0][7:0]  last complete write; the first byte received lands in wdata[NBYTES-1].
valid  output  1  one-clk pulse when wdata updates.
busy  output  1  1 while state != IDLE.

Behaviour:
- Reset values: sda_oe=0, valid=0, busy=0, wdata=0, state=IDLE, synchronizer flops=1. Reset mid-transfer clears everything asynchronously, discards partial data, and releases SDA immediately.
- Each input passes through SYNC_STAGES flops. Edges are detected by comparing the last two synchronized samples. Latency from pin to edge pulse is SYNC_STAGES+1 clk.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. START/STOP take priority over bit sampling. START in any state (including a repeated START) goes to ADDR with bit count 0 and the shift register cleared. STOP in any state goes to IDLE.
- Data is sampled on the synchronized SCL rise, MSB first. sda_oe changes only on the clk after a detected SCL fall, which guarantees SDA hold time.
- States: IDLE, ADDR, AACK, DATA, DACK, IGNORE.
- IDLE: waits for START.
- ADDR: shifts 8 bits (7 address bits + R/W). On the SCL fall after bit 8:
  - address == ADDR and R/W == 0: sda_oe=1, go to AACK, byte index = NBYTES-1.
  - otherwise: sda_oe stays 0, go to IGNORE.
- AACK: on the next SCL fall (end of the ACK clock), sda_oe=0, go to DATA.
- DATA: shifts 8 bits. On the SCL fall after bit 8, the byte is written to staging[index], sda_oe=1, go to DACK.
- DACK: on the ACK-clock SCL fall, sda_oe=0.
  - index == 0: wdata <= staging, valid=1 for exactly one clk, go to IGNORE. Any further bytes are NACKed.
  - otherwise: index decrements, go to DATA.
- IGNORE: sda_oe=0; leaves only on START or STOP.
- STOP or START before the last DACK completes: no valid, wdata unchanged, staging discarded.
- A 3-bit bit counter ignores wrap-around beyond 8; the byte index is clog2(NBYTES) bits wide, minimum 1.
- An SCL glitch shorter than the synchronizer depth is not filtered. Filtering is outside this block's scope.

Decomposition:
- Package i2c_pkg:
  - typedef enum i2c_rx_state_t for the six states;
  - localparam I2C_ADDR_BITS=7;
  - the default target address constant.
- Sub-module i2c_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, reset value 1. Instantiated once for SCL and once for SDA.
- The FSM, shift register, staging, and output logic stay in i2c_target_rx.

Test Plan:
- ADDR=7'h10, bench master (100 kHz-equivalent, clk 32x SCL) writes addr 0x10/W, bytes 0xC0, 0x03, STOP -> sda_oe=1 during all 3 ACK clocks; wdata[1]=8'hC0, wdata[0]=8'h03; exactly one valid pulse after the final ACK SCL fall; busy drops after STOP.
- Addr 0x11/W, bytes 0x55, 0xAA -> sda_oe never asserted, no valid, wdata unchanged (0x0000 after reset).
- Addr 0x10 with R/W=1 -> NACK on the address, IGNORE until STOP, no valid.
- Addr 0x10/W, byte 0x12, STOP; then a full write of 0x34, 0x56 -> the first transfer gives no valid and wdata stays at its prior value; the second gives wdata=16'h3456 with one valid.
- Repeated START in the middle of a data byte, then a full write of 0xDE, 0xAD -> the partial transfer is discarded; wdata=16'hDEAD with one valid. A third byte 0xFF after the two -> NACK, wdata unchanged.
- reset asserted while sda_oe=1 during AACK -> sda_oe, busy, and valid are 0 in the same cycle (async) and wdata=0; a following full write of 0x01, 0x02 succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
package i2c_pkg;

  localparam int I2C_ADDR_BITS = 7;
  localparam logic [I2C_ADDR_BITS-1:0] I2C_DEFAULT_ADDR = 7'h10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_AACK   = 3'd2,
    ST_DATA   = 3'd3,
    ST_DACK   = 3'd4,
    ST_IGNORE = 3'd5
  } i2c_rx_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line with registered rise/fall pulses.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Shift the line through the synchronizer and compare the last two settled samples.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Idle bus level is high, so everything resets to released-line values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // level is the sample the pulses were derived from, so it is aligned with them
  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: address match, ACK generation and NBYTES-byte capture.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_BITS-1:0] ADDR = I2C_DEFAULT_ADDR,
  parameter int NBYTES      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SCL,
  input  logic                   SDA,
  output logic                   sda_oe,
  output logic [NBYTES-1:0][7:0] wdata,
  output logic                   valid,
  output logic                   busy
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_rx_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic byte_full_q, byte_full_d;
  logic [7:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBYTES-1:0][7:0] staging_q, staging_d;
  logic [NBYTES-1:0][7:0] wdata_q, wdata_d;
  logic valid_q, valid_d;
  logic sda_oe_q, sda_oe_d;
  logic busy_q, busy_d;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .din(SCL), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .din(SDA), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // Next-state logic: bus conditions first, then per-state bit/ACK handling on SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_full_d = byte_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    staging_d   = staging_q;
    wdata_d     = wdata_q;
    valid_d     = 1'b0;
    sda_oe_d    = sda_oe_q;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
      shift_d     = 8'h00;
      staging_d   = '0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      byte_full_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shift_d     = {shift_q[6:0], sda_lvl};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_full_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            bit_cnt_d   = 3'd0;
            if (state_q == ST_ADDR) begin
              // LSB of the address byte is R/W; only writes to our address are ACKed
              if ((shift_q[7:1] == ADDR) && !shift_q[0]) begin
                sda_oe_d = 1'b1;
                idx_d    = IDX_LAST;
                state_d  = ST_AACK;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else begin
              staging_d[idx_q] = shift_q;
              sda_oe_d         = 1'b1;
              state_d          = ST_DACK;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_AACK: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            state_d     = ST_DATA;
          end else begin
            state_d = state_q;
          end
        end
        ST_DACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (idx_q == '0) begin
              wdata_d = staging_q;
              valid_d = 1'b1;
              state_d = ST_IGNORE;
            end else begin
              idx_d   = idx_q - IDX_W'(1);
              state_d = ST_DATA;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases SDA and drops any partial transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_full_q <= 1'b0;
      shift_q     <= 8'h00;
      idx_q       <= '0;
      staging_q   <= '0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_full_q <= byte_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      staging_q   <= staging_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign wdata  = wdata_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench master drives I2C writes; a scoreboard queue checks every valid strobe.
module tb_i2c_target_rx;

  localparam int NB = 2;
  localparam logic [6:0] TADDR = 7'h10;
  localparam int HP = 16;  // clk cycles per SCL half period (32x oversampling)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_oe, valid, busy;
  logic [NB-1:0][7:0] wdata;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [NB*8-1:0] exp_q[$];
  logic [NB*8-1:0] model_w = '0;
  logic [7:0] dbuf[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_rx #(.ADDR(TADDR), .NBYTES(NB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCL(scl_m), .SDA(sda_bus),
    .sda_oe(sda_oe), .wdata(wdata), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(wdata), 32'hFFFF_FFFF);
      end else begin
        check("wdata_on_valid", 32'(wdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic m_start;
    clks(HP/2); sda_m = 1'b1; clks(HP/2); scl_m = 1'b1;
    clks(HP/2); sda_m = 1'b0; clks(HP/2); scl_m = 1'b0;
  endtask

  task automatic m_stop;
    clks(HP/2); sda_m = 1'b0; clks(HP/2); scl_m = 1'b1;
    clks(HP/2); sda_m = 1'b1; clks(HP/2);
  endtask

  task automatic m_bit(input logic b, output logic rd);
    clks(HP/2); sda_m = b; clks(HP/2); scl_m = 1'b1;
    clks(HP/2); @(negedge clk); rd = sda_bus;
    clks(HP/2); scl_m = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, output logic ack);
    logic rd;
    for (int i = 7; i >= 0; i--) m_bit(b[i], rd);
    m_bit(1'b1, rd);
    ack = ~rd;
  endtask

  // Reference: a write to our address ACKs the first NB data bytes and yields their concatenation.
  task automatic xfer(input logic [7:0] ab, input logic do_stop);
    logic ack;
    logic addr_ok;
    logic [NB*8-1:0] exp_w;
    addr_ok = (ab[7:1] == TADDR) && (ab[0] == 1'b0);
    if (addr_ok && dbuf.size() >= NB) begin
      exp_w = '0;
      for (int i = 0; i < NB; i++) exp_w = (exp_w << 8) | {{(NB*8-8){1'b0}}, dbuf[i]};
      exp_q.push_back(exp_w);
      model_w = exp_w;
    end
    m_start;
    m_byte(ab, ack);
    check("addr_ack", 32'(ack), 32'(addr_ok));
    for (int i = 0; i < dbuf.size(); i++) begin
      m_byte(dbuf[i], ack);
      check($sformatf("data_ack%0d", i), 32'(ack), 32'(addr_ok && (i < NB)));
    end
    if (do_stop) begin
      m_stop;
      clks(6);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("wdata_held", 32'(wdata), 32'(model_w));
      check("valids_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    logic ack;
    logic rd;
    int k;
    int sel;
    logic [7:0] ab;

    clks(5);
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    reset = 1'b0;
    clks(5);

    dbuf = '{8'hC0, 8'h03};
    xfer({TADDR, 1'b0}, 1'b1);
    check("wdata_c003", 32'(wdata), 32'h0000_C003);

    dbuf = '{8'h55, 8'hAA};
    xfer(8'h22, 1'b1);

    dbuf = '{};
    xfer({TADDR, 1'b1}, 1'b1);

    dbuf = '{8'h12};
    xfer({TADDR, 1'b0}, 1'b1);
    dbuf = '{8'h34, 8'h56};
    xfer({TADDR, 1'b0}, 1'b1);
    check("wdata_3456", 32'(wdata), 32'h0000_3456);

    // Interrupted data byte, then a repeated START into a full write plus one extra byte
    m_start;
    m_byte({TADDR, 1'b0}, ack);
    check("partial_addr_ack", 32'(ack), 32'd1);
    m_bit(1'b1, rd); m_bit(1'b0, rd); m_bit(1'b1, rd);
    dbuf = '{8'hDE, 8'hAD, 8'hFF};
    xfer({TADDR, 1'b0}, 1'b1);
    check("wdata_dead", 32'(wdata), 32'h0000_DEAD);

    for (int it = 0; it < 14; it++) begin
      sel = $urandom_range(0, 3);
      if (sel <= 1) ab = {TADDR, 1'b0};
      else if (sel == 2) ab = {TADDR, 1'b1};
      else ab = 8'($urandom_range(0, 255));
      dbuf = '{};
      for (int j = 0; j < $urandom_range(0, 3); j++) dbuf.push_back(8'($urandom_range(0, 255)));
      xfer(ab, ($urandom_range(0, 1) == 1) || (it == 13));
    end

    // Reset while the address ACK is being driven
    m_start;
    for (int i = 7; i >= 0; i--) m_bit(ab_bit(i), rd);
    k = 0;
    while (!sda_oe && k < 40) begin @(posedge clk); k++; end
    check("oe_before_reset", 32'(sda_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_wdata", 32'(wdata), 32'd0);
    model_w = '0;
    clks(3);
    reset = 1'b0;
    m_stop;
    dbuf = '{8'h01, 8'h02};
    xfer({TADDR, 1'b0}, 1'b1);
    check("wdata_0102", 32'(wdata), 32'h0000_0102);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  function automatic logic ab_bit(input int i);
    logic [7:0] a;
    a = {TADDR, 1'b0};
    return a[i];
  endfunction

endmodule
